sram_bus_master: RTL and testbench
==================================

# sram_bus_master

Bus master for the team's single-port synchronous RAMs (single bank or the four-bank large array), driving the shared addr/data/cs/we/oe interface from the initiator side. It accepts read and write requests over a valid/ready handshake and sequences chip-select, write-enable and output-enable. It owns the bidirectional data bus, including turnaround, and returns read data over a second valid/ready handshake. It sits between a CPU or DMA front end and the RAM instance.

## Interface
Parameters:
- ADDR_WIDTH, 8, RAM word-address width
- DATA_WIDTH, 8, RAM data width
- BURST_WIDTH, 4, width of req_len

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  start word address
- req_wdata  in  DATA_WIDTH  write data
- req_len  in  BURST_WIDTH  beats minus one; used only with burst enabled
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  read data consumed
- rsp_rdata  out  DATA_WIDTH  read data; stable while rsp_valid
- busy  out  1  high in every state except IDLE
- mem_addr  out  ADDR_WIDTH  RAM address, registered
- mem_data  inout  DATA_WIDTH  RAM data bus; driven only in WRITE, Z otherwise
- mem_cs, mem_we, mem_oe  out  1 each  RAM controls, registered

## Operation
- States: IDLE, WRITE, ISSUE, CAPTURE, RESP.
- **IDLE:**
  - req_ready=1; all mem controls 0; bus Z.
  - On accept, latch addr/wdata/len/write and clear the beat counter.
  - Write goes to WRITE; read goes to ISSUE.
- **WRITE:**
  - cs=1, we=1, oe=0; mem_data driven with the latched wdata; RAM stores it at the end of the cycle.
  - If beats remain: addr+1, stay in WRITE. A burst write fills every address with the same wdata.
  - Otherwise go to IDLE.
- **ISSUE:** cs=1, we=0, oe=1; RAM latches mem[addr] at the end of the cycle; go to CAPTURE.
- **CAPTURE:** same controls and address held; mem_data is sampled into rsp_rdata at the end of the cycle; rsp_valid is set; go to RESP.
- **RESP:**
  - cs=we=oe=0; rsp_valid held and rsp_rdata frozen until rsp_ready.
  - On the handshake, if beats remain: addr+1, go to ISSUE. Otherwise go to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: a burst wraps from all-ones to zero.
- The beat counter compares to the latched len. len=0 is a single beat; maximum is 2^BURST_WIDTH beats.
- Writes produce no response; completion is busy falling.
- Bus safety:
  - The master drives mem_data only when mem_we=1.
  - mem_oe=1 only when mem_we=0.
  - Every transaction is preceded by at least one cycle with mem_cs=0 (IDLE or RESP), which gives read-to-write turnaround.

## Timing
- Reset: state IDLE; req_ready=0 while rst is high and 1 in the first cycle after release.
- All other outputs reset to 0; mem_data is Z.
- Reset mid-transaction aborts it:
  - the bus is released the next cycle;
  - no further writes occur;
  - pending rsp_valid is dropped.
- Write latency: accept at edge E0; WRITE is cycle E0–E1; data is in RAM after E1. A burst of N beats occupies N consecutive cycles.
- Read latency: accept at E0; ISSUE is E0–E1; CAPTURE is E1–E2; rsp_valid=1 after E2.
- Minimum read beat period is 3 cycles (ISSUE, CAPTURE, RESP with rsp_ready=1).
- Minimum request spacing is 1 IDLE cycle between transactions.
- rsp_ready asserted while rsp_valid=0 has no effect.
- req_valid outside IDLE is ignored; inputs need only be stable at the accept edge.

## Configuration
- Macro SRAM_BUS_MASTER_BURST_EN.
- **Defined:** req_len is honoured for reads and fill-writes as described above.
- **Undefined:** the req_len port is present but ignored, and every request is exactly one beat. The beat counter and increment logic are not compiled.

## Test plan
- Reset: hold rst 2 cycles mid-read, then release.
  - After release: mem_cs=mem_we=mem_oe=0, mem_data Z, rsp_valid=0.
  - req_ready=1 in the first cycle after release.
- Write/read: write 0xA5 to 0x12; after busy falls, read 0x12. Required: rsp_valid rises 2 edges after the read accept with rsp_rdata=0xA5.
- Backpressure: read 0x12 with rsp_ready=0 for 5 cycles.
  - rsp_valid held and rsp_rdata=0xA5 stable throughout.
  - mem_cs=0 and req_ready=0 throughout.
  - Transaction completes the cycle rsp_ready=1.
- Burst read wrap (BURST_EN): preload FE..01 with 1,2,3,4; read addr 0xFE, len=3. Required: mem_addr sequence FE, FF, 00, 01 and rsp_rdata 1, 2, 3, 4.
- Burst fill (BURST_EN): write 0x3C at 0x40, len=2.
  - mem_we high for exactly 3 consecutive cycles.
  - Reads of 0x40–0x42 return 0x3C; 0x43 unchanged.
- Turnaround: read then back-to-back write. Required: at least one mem_cs=0 cycle between them, and mem_data never driven while mem_oe=1.

Source files
------------

// File: rtl/sram_bus_master.sv
// sram_bus_master: valid/ready bus master for single-port synchronous RAMs with owned data-bus turnaround
// Define SRAM_BUS_MASTER_BURST_EN to honour req_len for burst reads and fill-writes.
module sram_bus_master #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BURST_WIDTH-1:0] req_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);
  typedef enum logic [2:0] {IDLE, WRITE, ISSUE, CAPTURE, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic rsp_valid_q, rsp_valid_d, cs_q, we_q, oe_q;
  logic accept, advance, more;
  assign accept  = req_valid && req_ready;
  assign advance = (state_q == WRITE) || (state_q == RESP && rsp_ready);
`ifdef SRAM_BUS_MASTER_BURST_EN
  logic [BURST_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d;
  assign more = cnt_q != len_q;
  always_comb begin
    len_d = accept ? req_len : len_q;
    cnt_d = accept ? '0 : (advance && more) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_len;
  assign unused_len = ^req_len;
  assign more = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    addr_d      = (advance && more) ? addr_q + 1'b1 : addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: if (accept) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        state_d = req_write ? WRITE : ISSUE;
      end
      WRITE:   state_d = more ? WRITE : IDLE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        rdata_d     = mem_data;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = more ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Controls are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      cs_q        <= state_d inside {WRITE, ISSUE, CAPTURE};
      we_q        <= state_d == WRITE;
      oe_q        <= state_d inside {ISSUE, CAPTURE};
    end
  end
  assign req_ready = (state_q == IDLE) && !rst;
  assign busy      = state_q != IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_cs    = cs_q;
  assign mem_we    = we_q;
  assign mem_oe    = oe_q;
  assign mem_data  = we_q ? wdata_q : 'z;
endmodule

// File: tb/tb_sram_bus_master.sv
// tb_sram_bus_master: directed checks of sram_bus_master against a behavioural synchronous RAM.
module tb_sram_bus_master;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_len = '0;
  logic req_ready, rsp_valid, busy, mem_cs, mem_we, mem_oe;
  logic [7:0] rsp_rdata, mem_addr;
  wire  [7:0] mem_data;
  int vecs = 0, errs = 0;
  logic [7:0] ram [256];
  logic [7:0] ram_q;

  always #5 clk = ~clk;

  sram_bus_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_len(req_len), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .busy(busy), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  always @(posedge clk) begin
    if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
    if (mem_cs && mem_oe) ram_q <= ram[mem_addr];
  end
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram_q : 'z;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [3:0] l);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_len = l;
    #1;
    chk("req_ready_before_accept", req_ready, 1'b1);
    tick;
    req_valid = 1'b0; req_addr = 8'h00; req_wdata = 8'h00; req_len = 4'h0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    req(1'b1, a, d, 4'h0);
    chk("wr_we", mem_we, 1'b1);
    chk("wr_oe", mem_oe, 1'b0);
    chk("wr_addr", mem_addr, a);
    chk("wr_data", mem_data, d);
    tick;
    chk("wr_done_busy", busy, 1'b0);
    chk("wr_done_cs", mem_cs, 1'b0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
    req(1'b0, a, 8'h00, 4'h0);
    chk("rd_issue_oe", mem_oe, 1'b1);
    chk("rd_issue_we", mem_we, 1'b0);
    chk("rd_issue_valid", rsp_valid, 1'b0);
    tick;
    chk("rd_capture_valid", rsp_valid, 1'b0);
    tick;
    chk("rd_resp_valid", rsp_valid, 1'b1);
    chk("rd_resp_data", rsp_rdata, exp);
    chk("rd_resp_cs", mem_cs, 1'b0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("rd_done_busy", busy, 1'b0);
    chk("rd_done_valid", rsp_valid, 1'b0);
  endtask

  initial begin
    logic [7:0] a;
    tick;
    tick;
    chk("rst_req_ready", req_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1'b1);
    chk("post_rst_cs", mem_cs, 1'b0);
    chk("post_rst_we", mem_we, 1'b0);
    chk("post_rst_oe", mem_oe, 1'b0);
    chk("post_rst_valid", rsp_valid, 1'b0);
    chk("post_rst_busy", busy, 1'b0);

    do_write(8'h12, 8'hA5);
    do_read(8'h12, 8'hA5);

    // read-response backpressure
    req(1'b0, 8'h12, 8'h00, 4'h0);
    tick;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_data", rsp_rdata, 8'hA5);
      chk("bp_cs", mem_cs, 1'b0);
      chk("bp_req_ready", req_ready, 1'b0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("bp_done_busy", busy, 1'b0);
    chk("bp_done_valid", rsp_valid, 1'b0);

    // rsp_ready while idle has no effect
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("idle_rsp_ready_valid", rsp_valid, 1'b0);
    chk("idle_rsp_ready_busy", busy, 1'b0);

    // reset held two cycles in the middle of a pending read response
    req(1'b0, 8'h12, 8'h00, 4'h0);
    tick;
    tick;
    chk("mid_rst_pre_valid", rsp_valid, 1'b1);
    rst = 1'b1;
    tick;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_cs", mem_cs, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b0);
    tick;
    rst = 1'b0;
    #1;
    chk("mid_rst_release_ready", req_ready, 1'b1);
    chk("mid_rst_release_oe", mem_oe, 1'b0);
    chk("mid_rst_release_busy", busy, 1'b0);

    // turnaround: read response completes, then a write follows at minimum spacing
    req(1'b0, 8'h12, 8'h00, 4'h0);
    tick;
    tick;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("ta_gap_cs", mem_cs, 1'b0);
    chk("ta_gap_oe", mem_oe, 1'b0);
    req(1'b1, 8'h20, 8'h5A, 4'h0);
    chk("ta_wr_we", mem_we, 1'b1);
    chk("ta_wr_oe", mem_oe, 1'b0);
    chk("ta_wr_data", mem_data, 8'h5A);
    tick;
    chk("ta_wr_done", busy, 1'b0);
    do_read(8'h20, 8'h5A);

`ifdef SRAM_BUS_MASTER_BURST_EN
    do_write(8'hFE, 8'h01);
    do_write(8'hFF, 8'h02);
    do_write(8'h00, 8'h03);
    do_write(8'h01, 8'h04);
    req(1'b0, 8'hFE, 8'h00, 4'h3);
    a = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      chk("burst_rd_addr", mem_addr, a);
      chk("burst_rd_oe", mem_oe, 1'b1);
      tick;
      tick;
      chk("burst_rd_valid", rsp_valid, 1'b1);
      chk("burst_rd_data", rsp_rdata, 8'(i + 1));
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      a = a + 8'h01;
    end
    chk("burst_rd_done", busy, 1'b0);

    do_write(8'h43, 8'h77);
    req(1'b1, 8'h40, 8'h3C, 4'h2);
    a = 8'h40;
    for (int i = 0; i < 3; i++) begin
      chk("fill_we", mem_we, 1'b1);
      chk("fill_addr", mem_addr, a);
      chk("fill_data", mem_data, 8'h3C);
      tick;
      a = a + 8'h01;
    end
    chk("fill_we_end", mem_we, 1'b0);
    chk("fill_busy_end", busy, 1'b0);
    do_read(8'h40, 8'h3C);
    do_read(8'h41, 8'h3C);
    do_read(8'h42, 8'h3C);
    do_read(8'h43, 8'h77);
`else
    do_write(8'h31, 8'h66);
    req(1'b1, 8'h30, 8'h11, 4'h3);
    chk("single_we", mem_we, 1'b1);
    tick;
    chk("single_we_end", mem_we, 1'b0);
    chk("single_busy_end", busy, 1'b0);
    do_read(8'h30, 8'h11);
    do_read(8'h31, 8'h66);
    req(1'b0, 8'h30, 8'h00, 4'h3);
    tick;
    tick;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("single_rd_busy", busy, 1'b0);
    chk("single_rd_cs", mem_cs, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout vectors=%0d", vecs);
    $fatal(1, "timeout");
  end
endmodule
